qdiv_seq: RTL and testbench

- Operand sequencer that sits directly in front of the fixed-point sign-magnitude divider and also collects its result.
- Accepts two's-complement Q(N,Q) operand pairs on a valid/ready stream and converts them to sign-magnitude.
- Screens divide-by-zero, pulses the divider start and tracks its complete flag.
- Converts the quotient back to two's complement and presents it with status on a valid/ready output stream.
- Used by the inversek2j datapath wherever a ratio (e.g. for acos/atan arguments) is needed.

---
 rtl/qdiv_seq_pkg.sv | 21 ++
 rtl/qdiv_seq_qfmt_conv.sv | 42 ++++
 rtl/qdiv_seq.sv | 148 ++++++++++++++
 tb/tb_qdiv_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qdiv_seq_pkg.sv
// Shared definitions for the divider operand sequencer: FSM states,
// default fixed-point format and the sign-magnitude saturation limits.
package qdiv_pkg;

  localparam int Q_DEF = 15;
  localparam int N_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_OUT       = 3'd4
  } state_e;

  // Largest magnitude a sign-magnitude word can hold, and its negation in
  // two's complement (the saturation limits at the default width).
  localparam logic [N_DEF-1:0] SM_MAX  = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] SAT_NEG = {1'b1, {(N_DEF-2){1'b0}}, 1'b1};

endpackage

// File: rtl/qdiv_seq_qfmt_conv.sv
// Combinational two's-complement <-> sign-magnitude converter; direction
// chosen by TO_SM. clamp_o flags the unrepresentable most-negative input.
module qfmt_conv #(
  parameter int N     = 32,
  parameter bit TO_SM = 1'b1
) (
  input  logic [N-1:0] x_i,
  output logic [N-1:0] y_o,
  output logic         clamp_o
);

  localparam logic [N-1:0] MIN_TC  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] NEG_MAX = {N{1'b1}};

  logic [N-1:0] neg_x;
  logic [N-1:0] mag;
  logic [N-1:0] neg_mag;

  assign neg_x   = -x_i;
  assign mag     = {1'b0, x_i[N-2:0]};
  assign neg_mag = -mag;

  always_comb begin
    y_o     = '0;
    clamp_o = 1'b0;
    if (TO_SM) begin
      // -2^(N-1) has no magnitude encoding: clamp to the largest negative one.
      if (x_i == MIN_TC) begin
        y_o     = NEG_MAX;
        clamp_o = 1'b1;
      end else if (x_i[N-1]) begin
        y_o = {1'b1, neg_x[N-2:0]};
      end else begin
        y_o = x_i;
      end
    end else begin
      // A signed zero magnitude negates to zero, so no negative zero survives.
      y_o = x_i[N-1] ? neg_mag : mag;
    end
  end

endmodule

// File: rtl/qdiv_seq.sv
// Operand sequencer/result collector for the sign-magnitude fixed-point divider.
// Optional build macro QDIV_SAT_EN saturates the quotient on overflow/div-by-zero.
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         i_clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_div_dividend,
  output logic [N-1:0] o_div_divisor,
  output logic         o_div_start,
  input  logic [N-1:0] i_div_quotient,
  input  logic         i_div_complete,
  input  logic         i_div_overflow,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_ovf,
  output logic         o_dz
);

  if (Q < 0 || Q >= N - 1) begin : g_bad_q
    $error("qdiv_seq: Q must lie in [0, N-2]");
  end

  state_e       state_q;
  logic [N-1:0] dvd_sm_q;
  logic [N-1:0] dvs_sm_q;
  logic [N-1:0] quo_q;
  logic         clamp_q;
  logic         ovf_q;
  logic         dz_q;

  logic [N-1:0] dvd_sm;
  logic [N-1:0] dvs_sm;
  logic [N-1:0] res_tc;
  logic         dvd_clamp;
  logic         dvs_clamp;
  logic         res_clamp;
  logic         dvs_zero;
  logic [N-1:0] quo_d;
  logic [N-1:0] dz_quo_d;

  qfmt_conv #(.N(N), .TO_SM(1'b1)) u_conv_dvd (
    .x_i     (i_dividend),
    .y_o     (dvd_sm),
    .clamp_o (dvd_clamp)
  );

  qfmt_conv #(.N(N), .TO_SM(1'b1)) u_conv_dvs (
    .x_i     (i_divisor),
    .y_o     (dvs_sm),
    .clamp_o (dvs_clamp)
  );

  qfmt_conv #(.N(N), .TO_SM(1'b0)) u_conv_res (
    .x_i     (i_div_quotient),
    .y_o     (res_tc),
    .clamp_o (res_clamp)
  );

  // Only zero has a zero magnitude; the clamped minimum is non-zero.
  assign dvs_zero = (i_divisor == '0);

`ifdef QDIV_SAT_EN
  localparam logic [N-1:0] SAT_POS_N = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_NEG_N = {1'b1, {(N-2){1'b0}}, 1'b1};

  function automatic logic [N-1:0] sat_val(input logic neg);
    return neg ? SAT_NEG_N : SAT_POS_N;
  endfunction

  logic res_sign;
  assign res_sign = dvd_sm_q[N-1] ^ dvs_sm_q[N-1];

  assign quo_d    = (i_div_overflow | res_clamp | clamp_q) ? sat_val(res_sign) : res_tc;
  assign dz_quo_d = sat_val(i_dividend[N-1] ^ i_divisor[N-1]);
`else
  assign quo_d    = res_tc;
  assign dz_quo_d = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dvd_sm_q <= '0;
      dvs_sm_q <= '0;
      quo_q    <= '0;
      clamp_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_in_valid) begin
            dvd_sm_q <= dvd_sm;
            dvs_sm_q <= dvs_sm;
            clamp_q  <= dvd_clamp | dvs_clamp;
            ovf_q    <= 1'b0;
            if (dvs_zero) begin
              dz_q    <= 1'b1;
              quo_q   <= dz_quo_d;
              state_q <= S_OUT;
            end else begin
              dz_q    <= 1'b0;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (i_div_complete) state_q <= S_WAIT_BUSY;
        end
        // The done flag seen before start is stale; wait for it to drop first.
        S_WAIT_BUSY: begin
          if (!i_div_complete) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_div_complete) begin
            quo_q   <= quo_d;
            ovf_q   <= i_div_overflow | res_clamp;
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Start fires only in a LAUNCH cycle where the divider reports idle.
  assign o_div_start    = (state_q == S_LAUNCH) & i_div_complete;
  assign o_in_ready     = (state_q == S_IDLE);
  assign o_out_valid    = (state_q == S_OUT);
  assign o_div_dividend = dvd_sm_q;
  assign o_div_divisor  = dvs_sm_q;
  assign o_quotient     = quo_q;
  assign o_ovf          = ovf_q | clamp_q;
  assign o_dz           = dz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed bench for qdiv_seq; the divider is played inline by the stimulus.
module tb_qdiv_seq;

  localparam int N = 32;
  localparam int Q = 15;

  logic         i_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [N-1:0] i_dividend = '0;
  logic [N-1:0] i_divisor = '0;
  logic [N-1:0] o_div_dividend;
  logic [N-1:0] o_div_divisor;
  logic         o_div_start;
  logic [N-1:0] i_div_quotient = '0;
  logic         i_div_complete = 1'b1;
  logic         i_div_overflow = 1'b0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic [N-1:0] o_quotient;
  logic         o_ovf;
  logic         o_dz;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  qdiv_seq #(.Q(Q), .N(N)) dut (
    .i_clk          (i_clk),
    .rst_n          (rst_n),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_dividend     (i_dividend),
    .i_divisor      (i_divisor),
    .o_div_dividend (o_div_dividend),
    .o_div_divisor  (o_div_divisor),
    .o_div_start    (o_div_start),
    .i_div_quotient (i_div_quotient),
    .i_div_complete (i_div_complete),
    .i_div_overflow (i_div_overflow),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_quotient     (o_quotient),
    .o_ovf          (o_ovf),
    .o_dz           (o_dz)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic accept(input logic [31:0] dvd, input logic [31:0] dvs, input string tag);
    i_in_valid = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    #1;
    chk({tag, " in_ready"}, o_in_ready, 1);
    tick();
    i_in_valid = 1'b0;
    #1;
  endtask

  // Entered with the DUT in LAUNCH and the divider idle.
  task automatic serve_div(input logic [31:0] q, input logic ov, input int lat, input string tag);
    chk({tag, " start"}, o_div_start, 1);
    tick();
    i_div_complete = 1'b0;
    #1;
    chk({tag, " start once"}, o_div_start, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk({tag, " start low"}, o_div_start, 0);
      chk({tag, " no early valid"}, o_out_valid, 0);
    end
    i_div_quotient = q;
    i_div_overflow = ov;
    i_div_complete = 1'b1;
    tick();
    chk({tag, " out_valid"}, o_out_valid, 1);
    chk({tag, " start idle"}, o_div_start, 0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst in_ready", o_in_ready, 1);
    chk("rst out_valid", o_out_valid, 0);
    chk("rst start", o_div_start, 0);
    chk("rst quotient", o_quotient, 32'h0);
    chk("rst ovf", o_ovf, 0);
    chk("rst dz", o_dz, 0);
    chk("rst div_dividend", o_div_dividend, 32'h0);

    // 3.0 / 2.0 with 10 cycles of backpressure
    accept(32'h0001_8000, 32'h0001_0000, "p32");
    chk("p32 sm dividend", o_div_dividend, 32'h0001_8000);
    chk("p32 sm divisor", o_div_divisor, 32'h0001_0000);
    chk("p32 busy in_ready", o_in_ready, 0);
    i_out_ready = 1'b0;
    serve_div(32'h0000_C000, 1'b0, 3, "p32");
    chk("p32 quotient", o_quotient, 32'h0000_C000);
    chk("p32 ovf", o_ovf, 0);
    chk("p32 dz", o_dz, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp quotient", o_quotient, 32'h0000_C000);
      chk("bp in_ready", o_in_ready, 0);
      chk("bp out_valid", o_out_valid, 1);
    end
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    i_dividend  = 32'h0000_8000;
    i_divisor   = 32'h0000_8000;
    tick();
    chk("bubble in_ready", o_in_ready, 1);
    chk("bubble out_valid", o_out_valid, 0);
    i_in_valid = 1'b0;

    // -3.0 / 2.0
    accept(32'hFFFE_8000, 32'h0001_0000, "n32");
    chk("n32 sm dividend", o_div_dividend, 32'h8001_8000);
    serve_div(32'h8000_C000, 1'b0, 2, "n32");
    chk("n32 quotient", o_quotient, 32'hFFFF_4000);
    chk("n32 ovf", o_ovf, 0);
    chk("n32 dz", o_dz, 0);
    tick();
    chk("n32 done in_ready", o_in_ready, 1);

    // 1.0 / 0
    accept(32'h0000_8000, 32'h0000_0000, "dzp");
    chk("dzp out_valid", o_out_valid, 1);
    chk("dzp dz", o_dz, 1);
    chk("dzp ovf", o_ovf, 0);
    chk("dzp start", o_div_start, 0);
`ifdef QDIV_SAT_EN
    chk("dzp quotient", o_quotient, 32'h7FFF_FFFF);
`else
    chk("dzp quotient", o_quotient, 32'h0000_0000);
`endif
    tick();
    chk("dzp done in_ready", o_in_ready, 1);

    // -1.0 / 0
    accept(32'hFFFF_8000, 32'h0000_0000, "dzn");
    chk("dzn dz", o_dz, 1);
    chk("dzn start", o_div_start, 0);
`ifdef QDIV_SAT_EN
    chk("dzn quotient", o_quotient, 32'h8000_0001);
`else
    chk("dzn quotient", o_quotient, 32'h0000_0000);
`endif
    tick();

    // Divider overflow
    accept(32'h4000_0000, 32'h0000_0001, "ovf");
    chk("ovf sm divisor", o_div_divisor, 32'h0000_0001);
    serve_div(32'h1234_5678, 1'b1, 4, "ovf");
    chk("ovf flag", o_ovf, 1);
    chk("ovf dz", o_dz, 0);
`ifdef QDIV_SAT_EN
    chk("ovf quotient", o_quotient, 32'h7FFF_FFFF);
`else
    chk("ovf quotient", o_quotient, 32'h1234_5678);
`endif
    tick();
    i_div_overflow = 1'b0;

    // Busy divider while in LAUNCH
    i_div_complete = 1'b0;
    accept(32'h0001_8000, 32'h0001_0000, "busy");
    for (int i = 0; i < 3; i++) begin
      chk("busy no start", o_div_start, 0);
      chk("busy in_ready", o_in_ready, 0);
      tick();
    end
    i_div_complete = 1'b1;
    #1;
    serve_div(32'h0000_C000, 1'b0, 2, "busy");
    chk("busy quotient", o_quotient, 32'h0000_C000);
    tick();

    // Most-negative dividend is clamped
    accept(32'h8000_0000, 32'h0000_8000, "clmp");
    chk("clmp sm dividend", o_div_dividend, 32'hFFFF_FFFF);
    serve_div(32'h8000_4000, 1'b0, 2, "clmp");
    chk("clmp ovf", o_ovf, 1);
`ifdef QDIV_SAT_EN
    chk("clmp quotient", o_quotient, 32'h8000_0001);
`else
    chk("clmp quotient", o_quotient, 32'hFFFF_C000);
`endif
    tick();

    // Signed zero quotient
    accept(32'hFFFF_FFFF, 32'h4000_0000, "nz");
    chk("nz sm dividend", o_div_dividend, 32'h8000_0001);
    serve_div(32'h8000_0000, 1'b0, 2, "nz");
    chk("nz quotient", o_quotient, 32'h0000_0000);
    chk("nz ovf", o_ovf, 0);
    tick();

    // Reset while waiting for the divider
    accept(32'h0001_8000, 32'h0001_0000, "rwd");
    tick();
    i_div_complete = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_div_complete = 1'b1;
    #1;
    chk("rwd in_ready", o_in_ready, 1);
    chk("rwd out_valid", o_out_valid, 0);
    accept(32'h0000_8000, 32'h0000_8000, "one");
    serve_div(32'h0000_8000, 1'b0, 2, "one");
    chk("one quotient", o_quotient, 32'h0000_8000);
    chk("one ovf", o_ovf, 0);
    chk("one dz", o_dz, 0);
    tick();
    chk("one done in_ready", o_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
